// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 10416;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// Single-character UART receiver: line synchronizer, framing FSM and byte shifter.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       accept_c,
  output logic       ferr_c,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state_q, state_d;
  logic [1:0]       sync_q;
  logic             rx_s, rx_prev_q, fall;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             at_half, at_full;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rxd};
      rx_prev_q <= sync_q[1];
    end
  end

  assign rx_s    = sync_q[1];
  assign fall    = rx_prev_q & ~rx_s;
  assign at_half = (cnt_q == HALF_M1);
  assign at_full = (cnt_q == FULL_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (fall) state_d = START;
      START:     if (at_half) state_d = rx_s ? IDLE : DATA;
      DATA:      if (at_full && (bit_q == 3'd7)) state_d = STOP;
      STOP:      if (at_full) state_d = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    accept_c = 1'b0;
    ferr_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
      end
      START: if (at_half) cnt_d = '0;
      DATA: begin
        if (at_full) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = 3'(bit_q + 3'd1);
        end
      end
      STOP: begin
        if (at_full) begin
          cnt_d    = '0;
          accept_c = rx_s;
          ferr_c   = ~rx_s;
        end
      end
      WAIT_IDLE: cnt_d = '0;
      default:   cnt_d = '0;
    endcase
    if (clr) begin
      cnt_d    = '0;
      bit_d    = '0;
      shift_d  = '0;
      accept_c = 1'b0;
      ferr_c   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      busy    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      busy    <= (state_d != IDLE);
    end
  end

  assign data = shift_q;

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver that assembles CHAR_NR accepted chars into an MSB-first array.
module uart_rx_top
  import uart_pkg::*;
#(
  parameter int unsigned CHAR_NR      = 8,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd_i,
  input  logic                 clr_i,
  output logic [7:0]           char_o,
  output logic                 char_valid_o,
  output logic                 frame_err_o,
  output logic                 busy_o,
  output logic [CHAR_NR*8-1:0] char_array_o,
  output logic                 char_array_valid_o
);

  localparam int unsigned IDX_W = (CHAR_NR > 1) ? $clog2(CHAR_NR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAR_NR - 1);

  logic [7:0]           rx_data;
  logic                 rx_accept_c, rx_ferr_c;
  logic [IDX_W-1:0]     idx_q;
  logic [CHAR_NR*8-1:0] buf_q, buf_ins;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_i),
    .rxd      (rxd_i),
    .data     (rx_data),
    .accept_c (rx_accept_c),
    .ferr_c   (rx_ferr_c),
    .busy     (busy_o)
  );

  // Char k lands in the k-th byte counted from the MSB end
  always_comb begin
    buf_ins = buf_q;
    for (int unsigned k = 0; k < CHAR_NR; k++) begin
      if (idx_q == IDX_W'(k)) buf_ins[(CHAR_NR-1-k)*8 +: 8] = rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q              <= '0;
      buf_q              <= '0;
      char_o             <= '0;
      char_valid_o       <= 1'b0;
      frame_err_o        <= 1'b0;
      char_array_o       <= '0;
      char_array_valid_o <= 1'b0;
    end else if (clr_i) begin
      idx_q              <= '0;
      buf_q              <= '0;
      char_o             <= '0;
      char_valid_o       <= 1'b0;
      frame_err_o        <= 1'b0;
      char_array_o       <= '0;
      char_array_valid_o <= 1'b0;
    end else begin
      char_valid_o       <= 1'b0;
      char_array_valid_o <= 1'b0;
      frame_err_o        <= rx_ferr_c;
      if (rx_accept_c) begin
        char_o       <= rx_data;
        char_valid_o <= 1'b1;
        buf_q        <= buf_ins;
        if (idx_q == LAST_IDX) begin
          char_array_o       <= buf_ins;
          char_array_valid_o <= 1'b1;
          idx_q              <= '0;
        end else begin
          idx_q <= idx_q + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_top.sv
// Scoreboard bench for uart_rx_top at CLKS_PER_BIT=8, CHAR_NR=4.
module tb_uart_rx_top;

  localparam int unsigned CPB = 8;
  localparam int unsigned NCH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rxd_i;
  logic            clr_i;
  logic [7:0]      char_o;
  logic            char_valid_o;
  logic            frame_err_o;
  logic            busy_o;
  logic [NCH*8-1:0] char_array_o;
  logic            char_array_valid_o;

  uart_rx_top #(
    .CHAR_NR      (NCH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rxd_i              (rxd_i),
    .clr_i              (clr_i),
    .char_o             (char_o),
    .char_valid_o       (char_valid_o),
    .frame_err_o        (frame_err_o),
    .busy_o             (busy_o),
    .char_array_o       (char_array_o),
    .char_array_valid_o (char_array_valid_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  exp_char[$];
  logic [31:0] exp_arr[$];
  int          exp_ferr = 0;

  // Reference model of the array assembly
  logic [31:0] m_buf = '0;
  int          m_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    $display("FAIL %s: got unexpected pulse expected none", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse
  logic [7:0]  mon_ch;
  logic [31:0] mon_arr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (char_valid_o) begin
        if (exp_char.size() == 0) unexpected("char_valid_o");
        else begin
          mon_ch = exp_char.pop_front();
          check("char_o", 32'(char_o), 32'(mon_ch));
        end
      end
      if (char_array_valid_o) begin
        check("array_with_char", 32'(char_valid_o), 32'd1);
        if (exp_arr.size() == 0) unexpected("char_array_valid_o");
        else begin
          mon_arr = exp_arr.pop_front();
          check("char_array_o", char_array_o, mon_arr);
        end
      end
      if (frame_err_o) begin
        if (exp_ferr == 0) unexpected("frame_err_o");
        else begin
          exp_ferr--;
          check("ferr_without_char", 32'(char_valid_o), 32'd0);
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue a frame; expected response is queued before driving the line
  task automatic send_char(input logic [7:0] b, input logic stop_ok, input int low_hold);
    if (stop_ok) begin
      exp_char.push_back(b);
      m_buf[(NCH-1-m_idx)*8 +: 8] = b;
      if (m_idx == NCH - 1) begin
        exp_arr.push_back(m_buf);
        m_idx = 0;
      end else m_idx++;
    end else exp_ferr++;
    rxd_i = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd_i = b[i];
      wait_clks(CPB);
    end
    rxd_i = stop_ok;
    wait_clks(CPB);
    if (!stop_ok) wait_clks(low_hold);
    rxd_i = 1'b1;
    wait_clks(2 * CPB);
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    wait_clks(1);
    clr_i = 1'b0;
    m_idx = 0;
    m_buf = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_char_o"}, 32'(char_o), 32'd0);
    check({tag, "_char_valid_o"}, 32'(char_valid_o), 32'd0);
    check({tag, "_frame_err_o"}, 32'(frame_err_o), 32'd0);
    check({tag, "_busy_o"}, 32'(busy_o), 32'd0);
    check({tag, "_char_array_o"}, char_array_o, 32'd0);
    check({tag, "_char_array_valid_o"}, 32'(char_array_valid_o), 32'd0);
  endtask

  int busy_cnt;

  initial begin
    rst_n = 1'b0;
    rxd_i = 1'b1;
    clr_i = 1'b0;
    wait_clks(3);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_clks(4);

    // Single valid char
    send_char(8'h41, 1'b1, 0);
    check("char_0x41_held", 32'(char_o), 32'h41);

    // Clear, then a full array
    pulse_clr();
    check("clr_char_o", 32'(char_o), 32'd0);
    send_char(8'h31, 1'b1, 0);
    send_char(8'h32, 1'b1, 0);
    send_char(8'h33, 1'b1, 0);
    send_char(8'h34, 1'b1, 0);
    check("array_31323334", char_array_o, 32'h31323334);

    // Framing error with break, then a valid char advancing index once
    send_char(8'h55, 1'b0, 40);
    send_char(8'h66, 1'b1, 0);
    check("char_after_ferr", 32'(char_o), 32'h66);
    send_char(8'hA1, 1'b1, 0);
    send_char(8'hA2, 1'b1, 0);
    send_char(8'hA3, 1'b1, 0);
    check("array_66a1a2a3", char_array_o, 32'h66A1A2A3);

    // Short low glitch on an idle line
    rxd_i = 1'b0;
    wait_clks(2);
    rxd_i = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      wait_clks(1);
      if (busy_o) busy_cnt++;
    end
    check("glitch_busy_seen", 32'(busy_cnt > 0), 32'd1);
    check("glitch_busy_le6", 32'(busy_cnt <= 6), 32'd1);

    // Reset asserted during data bit 3
    rxd_i = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 3; i++) begin
      rxd_i = i[0];
      wait_clks(CPB);
    end
    rxd_i = 1'b1;
    wait_clks(CPB / 2);
    rst_n = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    wait_clks(3);
    check("reset_hold_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1;
    m_idx = 0;
    m_buf = '0;
    wait_clks(20);
    send_char(8'h7E, 1'b1, 0);
    check("char_after_reset", 32'(char_o), 32'h7E);

    // Two chars, clear, then a fresh array
    send_char(8'h11, 1'b1, 0);
    send_char(8'h12, 1'b1, 0);
    pulse_clr();
    check("clr_char_o_2", 32'(char_o), 32'd0);
    check("clr_char_array_o", char_array_o, 32'd0);
    send_char(8'h01, 1'b1, 0);
    send_char(8'h02, 1'b1, 0);
    send_char(8'h03, 1'b1, 0);
    send_char(8'h04, 1'b1, 0);
    check("array_01020304", char_array_o, 32'h01020304);

    wait_clks(20);
    check("pending_chars", 32'(exp_char.size()), 32'd0);
    check("pending_arrays", 32'(exp_arr.size()), 32'd0);
    check("pending_ferr", 32'(exp_ferr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_top.md
UART_RX_TOP -- requirements
Module: uart_rx_top

Interface
REQ-001 SHALL have parameter CHAR_NR, default 8: number of chars assembled per array.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 10416: system clocks per UART bit (100 MHz / 9600 baud); minimum 4.
REQ-003 SHALL have port clk, input, 1: system clock; one clock, all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port rxd_i, input, 1: serial receive line, asynchronous to clk, idle high.
REQ-006 SHALL have port clr_i, input, 1: synchronous clear of receiver and array state.
REQ-007 SHALL have port char_o, output, 8: last correctly received char.
REQ-008 SHALL have port char_valid_o, output, 1: one-cycle pulse when char_o is updated.
REQ-009 SHALL have port frame_err_o, output, 1: one-cycle pulse on stop-bit error.
REQ-010 SHALL have port busy_o, output, 1: high whenever the FSM is not IDLE.
REQ-011 SHALL have port char_array_o, output, CHAR_NR*8: last completed char array.
REQ-012 SHALL have port char_array_valid_o, output, 1: one-cycle pulse when char_array_o is updated.

Function
REQ-013 SHALL pass rxd_i through a 2-flop synchronizer (reset value 1) before any use.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-015 IDLE: synchronized line 1->0 edge -> START, bit counter cleared.
REQ-016 START: after CLKS_PER_BIT/2 clocks, sample line; 0 -> DATA; 1 -> IDLE (glitch rejected, no pulse).
REQ-017 DATA: sample every CLKS_PER_BIT clocks at bit centre; 8 bits, LSB first; after bit 7 -> STOP.
REQ-018 STOP: sample after CLKS_PER_BIT clocks; 1 -> char accepted, IDLE; 0 -> frame_err_o pulse, char discarded, WAIT_IDLE.
REQ-019 WAIT_IDLE: stay until synchronized line is 1, then IDLE; no false start on held-low (break) line.
REQ-020 Accepted char: char_o and char_valid_o update in the clock after the stop-bit sample.
REQ-021 Accepted chars SHALL fill the array MSB byte first: char k (0-based) occupies bits [(CHAR_NR-k)*8-1 : (CHAR_NR-k-1)*8], matching the transmit order of uart_top.
REQ-022 Completion of the CHAR_NR-th char SHALL copy the assembly buffer to char_array_o, pulse char_array_valid_o together with char_valid_o, and reset the char index to 0 (wrap).
REQ-023 A framing error SHALL NOT advance the char index; partially assembled chars are kept.
REQ-024 char_array_o SHALL hold its value until the next completed array, reset or clr_i.
REQ-025 clr_i SHALL take priority over all reception: FSM -> IDLE, index 0, assembly buffer, char_o, char_array_o to 0, no pulses that cycle; a frame in progress is dropped.
REQ-026 Baud counter width SHALL be $clog2(CLKS_PER_BIT)+1; no overflow at any legal parameter.

Reset
REQ-027 On rst_n low: FSM IDLE, counters 0, index 0, synchronizer 1, char_o 0, char_valid_o 0, frame_err_o 0, busy_o 0, char_array_o 0, char_array_valid_o 0.
REQ-028 Reset mid-frame SHALL abort the frame; after release the receiver resynchronizes on the next falling edge only.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum typedef and the default CLKS_PER_BIT constant.
REQ-030 Sub-module uart_rx_byte SHALL contain synchronizer, FSM and byte shifter; uart_rx_top SHALL add array assembly and clr handling.

Verification (CLKS_PER_BIT=8, CHAR_NR=4)
REQ-031 Send 0x41 with valid frame -> one char_valid_o pulse, char_o=0x41, frame_err_o stays 0.
REQ-032 Send 0x31,0x32,0x33,0x34 -> char_array_valid_o pulses once with the 4th char_valid_o, char_array_o=0x31323334.
REQ-033 Send 0x55 with stop bit 0, line held low 40 clocks, then 0x66 -> frame_err_o pulse, no char for 0x55, char_o=0x66, index advanced by 1 only.
REQ-034 Low glitch of 2 clocks on idle line -> returns to IDLE, no pulses, busy_o high at most 6 clocks.
REQ-035 Assert rst_n low during bit 3 of a frame, then send 0x7E -> all outputs 0 during reset, then char_o=0x7E.
REQ-036 After 2 chars, pulse clr_i, send 4 chars 0x01..0x04 -> char_array_o=0x01020304.
